mem_bus_initiator: RTL and testbench
====================================

Name: mem_bus_initiator

Overview:
- Synthesizable request initiator for the memory bus; drives the transmit side of a bus whose responder is the cache (or memory) receive port.
- On `start`, runs a self-checking pass: writes NUM_OPS generated words, then reads them back and compares each against the regenerated pattern.
- Replaces the behavioural cache testbench for on-chip bring-up. Reports `done`, `pass` and an error count.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_OPS, 64, words written then read (1..65535)
- ADDR_BASE, 0, address of op 0
- ADDR_STRIDE, 4, address increment per op
- DATA_SEED, 32'hA5A5_0000, pattern offset
- DATA_MUL, 32'h0001_0003, pattern multiplier
- TIMEOUT, 255, max cycles waiting for a response (>=1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a run; sampled only in IDLE and DONE
- req_valid  out  1  request valid
- req_write  out  1  1 = write, 0 = read
- req_addr  out  ADDR_W  request address
- req_data  out  DATA_W  write data; 0 on reads
- req_ready  in  1  responder accepts request
- rsp_valid  in  1  response pulse, one per accepted request (writes included)
- rsp_data  in  DATA_W  read data; ignored for writes
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  valid when done; 1 iff err_count == 0
- err_count  out  16  mismatches plus timeouts, saturating at 16'hFFFF
- op_index  out  16  index of the current op

Behaviour:
- Reset (synchronous, active-high): state IDLE; every output 0. Reset wins over all other inputs in the same cycle, including mid-transaction. A pending responder transaction is abandoned; the responder is reset alongside.
- Pattern, with all arithmetic truncated to port width, no overflow flag:
  - addr(i) = ADDR_BASE + i*ADDR_STRIDE mod 2^ADDR_W
  - data(i) = i*DATA_MUL + DATA_SEED mod 2^DATA_W
- FSM states: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
- IDLE/DONE:
  - start=1 clears err_count, op_index, done and pass; sets busy; enters WR_REQ next cycle.
  - start while busy is ignored.
- WR_REQ:
  - req_valid=1, req_write=1, req_addr=addr(op_index), req_data=data(op_index).
  - Request transfers on the cycle with req_valid & req_ready; the FSM then enters WR_WAIT and drops req_valid the following cycle.
  - Address, data and write are held stable while valid and not ready.
- WR_WAIT:
  - req_valid=0; waits for rsp_valid.
  - On rsp_valid: if op_index == NUM_OPS-1, reset op_index to 0 and go to RD_REQ; else increment op_index and go to WR_REQ.
- RD_REQ: as WR_REQ but req_write=0 and req_data=0; goes to RD_WAIT.
- RD_WAIT:
  - On rsp_valid, compare rsp_data with data(op_index); on mismatch, err_count+1.
  - If last op, go to DONE; else increment op_index and go to RD_REQ.
- DONE: busy=0, done=1, pass=(err_count==0); outputs held.
- Exactly one request outstanding; no new request before the prior response.
- Timeout:
  - A wait counter clears on entering either *_WAIT state.
  - If it reaches TIMEOUT with no rsp_valid, err_count+1 and the FSM advances exactly as if the response had arrived. In RD_WAIT no data compare is made on a timeout.
  - A late response arriving in a *_REQ state is ignored.
- Same-cycle response: rsp_valid in the same cycle as request acceptance is not legal for the bus; it is ignored (the FSM is still in *_REQ).
- Minimum latency per op with zero-wait responder (ready=1, rsp one cycle after acceptance): 2 cycles. A full run is 4*NUM_OPS + 1 cycles from start to done.
- op_index and err_count are registered; the pattern is computed combinationally from op_index, with a single multiplier.

Test Plan:
- Ideal responder (ready=1, rsp next cycle, correct storage), NUM_OPS=4 -> writes 0xA5A50000, 0xA5A60003, 0xA5A70006, 0xA5A80009 to addrs 0, 4, 8, 12; reads match; done after 17 cycles; pass=1, err_count=0.
- Responder holds req_ready=0 for 3 cycles on op 2 -> req_addr=8 and req_data stable throughout; single accepted transfer; pass=1.
- Responder corrupts read of addr 4 (returns 0) -> err_count=1, pass=0, done=1.
- Responder never answers read of op 1, TIMEOUT=10 -> advance after 10 wait cycles; err_count=1; run completes; a late rsp_valid during RD_REQ is ignored.
- Assert rst during WR_WAIT of op 2 -> next cycle all outputs 0, state IDLE; a new start runs cleanly to pass=1.
- start pulsed while busy -> ignored. start in DONE -> counters cleared, second run identical to the first.

Source files
------------

// File: rtl/mem_bus_initiator.sv
// rtl/mem_bus_initiator.sv - self-checking memory bus request initiator
//
// Writes NUM_OPS generated words to the responder, reads them back and
// compares each against the regenerated pattern. Reports done/pass and a
// saturating count of data mismatches plus response timeouts.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   start                 begin a run (honoured only when idle or done)
//   req_valid/req_ready   request handshake; req_write, req_addr, req_data
//                         describe the request (req_data is 0 on reads)
//   rsp_valid, rsp_data   one response pulse per accepted request
//   busy, done, pass      run status; pass is meaningful while done=1
//   err_count, op_index   error tally and index of the op in flight
module mem_bus_initiator #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_OPS     = 64,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = '0,
  parameter logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(4),
  parameter logic [DATA_W-1:0] DATA_SEED   = DATA_W'(32'hA5A5_0000),
  parameter logic [DATA_W-1:0] DATA_MUL    = DATA_W'(32'h0001_0003),
  parameter int unsigned       TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              req_valid,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [15:0]       op_index
);

  localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [15:0]       LAST_OP   = 16'(NUM_OPS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       op_index_q, op_index_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [DATA_W-1:0] data_pat;
  logic              advance;
  logic              err_inc;

  // The data pattern owns the only multiplier; the address walks by
  // accumulating the stride alongside op_index instead.
  assign data_pat = DATA_W'(op_index_q) * DATA_MUL + DATA_SEED;

  always_comb begin
    state_d     = state_q;
    op_index_d  = op_index_q;
    err_count_d = err_count_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    advance     = 1'b0;
    err_inc     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_index_d  = '0;
          err_count_d = '0;
          addr_d      = ADDR_BASE;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          state_d     = WR_REQ;
        end
      end
      WR_REQ, RD_REQ: begin
        // Responses seen here are late or same-cycle and are dropped.
        if (req_ready) begin
          wait_cnt_d = '0;
          state_d    = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
        end
      end
      WR_WAIT, RD_WAIT: begin
        if (rsp_valid) begin
          advance = 1'b1;
          err_inc = (state_q == RD_WAIT) && (rsp_data != data_pat);
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Timed out: count it and move on as if the response arrived.
          advance = 1'b1;
          err_inc = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        if (err_inc && (err_count_q != 16'hFFFF)) begin
          err_count_d = err_count_q + 16'd1;
        end

        if (advance) begin
          if (op_index_q == LAST_OP) begin
            op_index_d = '0;
            addr_d     = ADDR_BASE;
            if (state_q == WR_WAIT) begin
              state_d = RD_REQ;
            end else begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_count_d == 16'd0);
            end
          end else begin
            op_index_d = op_index_q + 16'd1;
            addr_d     = addr_q + ADDR_STRIDE;
            state_d    = (state_q == WR_WAIT) ? WR_REQ : RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_index_q  <= '0;
      err_count_q <= '0;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_index_q  <= op_index_d;
      err_count_q <= err_count_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // Request fields are decoded from the registered state; address and data
  // are forced to 0 outside the request states so idle/reset outputs are 0.
  assign req_valid = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign req_write = (state_q == WR_REQ);
  assign req_addr  = req_valid ? addr_q : '0;
  assign req_data  = (state_q == WR_REQ) ? data_pat : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign op_index  = op_index_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb/tb_mem_bus_initiator.sv - directed self-checking bench for mem_bus_initiator
module tb_mem_bus_initiator;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy, done, pass;
  logic [15:0] err_count, op_index;

  int n_total = 0;
  int n_pass  = 0;

  // responder configuration
  bit          stall_en, stall_write, stall_used, inject_late;
  int          stall_n, stall_left;
  logic [31:0] stall_addr;
  bit          corrupt_en, drop_en;
  logic [31:0] corrupt_addr, drop_addr;
  bit          meas;
  int          wcnt, last_wait;

  // responder state
  bit          have_acc;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] mem [16];
  req_t        log_q [$];
  req_t        exp_tab [8];

  mem_bus_initiator #(.NUM_OPS(4), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .start(start),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .op_index(op_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bus responder: decides ready/response at each falling edge.
  initial begin
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_data  = '0;
      if (rst) begin
        have_acc   = 0;
        stall_left = 0;
        meas       = 0;
        req_ready  = 1'b1;
      end else begin
        if (meas) begin
          if (req_valid) begin
            meas      = 0;
            last_wait = wcnt;
          end else begin
            wcnt++;
          end
        end
        if (have_acc) begin
          have_acc = 0;
          if (!(!acc_write && drop_en && acc_addr == drop_addr)) begin
            rsp_valid = 1'b1;
            if (acc_write) rsp_data = '0;
            else if (corrupt_en && acc_addr == corrupt_addr) rsp_data = '0;
            else rsp_data = mem[acc_addr[5:2]];
          end
        end
        if (req_valid) begin
          if (stall_en && !stall_used && req_write == stall_write && req_addr == stall_addr) begin
            stall_used = 1;
            stall_left = stall_n;
          end
          if (stall_left > 0) begin
            stall_left--;
            req_ready = 1'b0;
            chk("stall_hold", 64'({req_valid, req_write, req_addr, req_data}),
                64'({1'b1, stall_write, stall_addr, (stall_write ? 32'hA5A7_0006 : 32'h0)}));
            if (inject_late) begin
              rsp_valid = 1'b1;
              rsp_data  = 32'hDEAD_BEEF;
            end
          end else begin
            req_ready = 1'b1;
            have_acc  = 1;
            acc_write = req_write;
            acc_addr  = req_addr;
            if (req_write) mem[req_addr[5:2]] = req_data;
            log_q.push_back('{req_write, req_addr, req_data});
            if (!req_write && drop_en && req_addr == drop_addr) begin
              meas = 1;
              wcnt = 0;
            end
          end
        end else begin
          req_ready = 1'b1;
        end
      end
    end
  end

  task automatic compare_log();
    chk("log_size", 64'(log_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      chk($sformatf("req%0d", i), 64'({log_q[i].wr, log_q[i].addr, log_q[i].data}),
          64'({exp_tab[i].wr, exp_tab[i].addr, exp_tab[i].data}));
  endtask

  // Call at a falling edge; returns rising edges from the start edge to done.
  task automatic run(input int pulse_at, output int cycles);
    log_q.delete();
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_clr", 64'({done, pass, err_count, op_index}), 64'd0);
    while (!done && cycles < 300) begin
      start = (cycles == pulse_at);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    chk("run_done", 64'(done), 64'd1);
  endtask

  initial begin
    int cyc;
    int wr8;
    int found;

    exp_tab[0] = '{1'b1, 32'd0,  32'hA5A5_0000};
    exp_tab[1] = '{1'b1, 32'd4,  32'hA5A6_0003};
    exp_tab[2] = '{1'b1, 32'd8,  32'hA5A7_0006};
    exp_tab[3] = '{1'b1, 32'd12, 32'hA5A8_0009};
    exp_tab[4] = '{1'b0, 32'd0,  32'h0};
    exp_tab[5] = '{1'b0, 32'd4,  32'h0};
    exp_tab[6] = '{1'b0, 32'd8,  32'h0};
    exp_tab[7] = '{1'b0, 32'd12, 32'h0};

    stall_en = 0; inject_late = 0; corrupt_en = 0; drop_en = 0;
    stall_used = 0; stall_n = 0; stall_left = 0; last_wait = 0;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("rst_ctl", 64'({req_valid, req_write, busy, done, pass, err_count, op_index}), 64'd0);
    chk("rst_bus", {req_addr, req_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // ideal responder, with a start pulse while busy
    run(6, cyc);
    chk("ideal_cycles", 64'(cyc), 64'd17);
    chk("ideal_status", 64'({done, pass, busy, err_count}), 64'({1'b1, 1'b1, 1'b0, 16'd0}));
    compare_log();

    // ready held low for 3 cycles on write op 2, started from DONE
    stall_en = 1; stall_write = 1; stall_addr = 32'd8; stall_n = 3; stall_used = 0;
    run(-1, cyc);
    stall_en = 0;
    chk("stall_cycles", 64'(cyc), 64'd20);
    chk("stall_status", 64'({pass, err_count}), 64'({1'b1, 16'd0}));
    wr8 = 0;
    foreach (log_q[i]) if (log_q[i].wr && log_q[i].addr == 32'd8) wr8++;
    chk("stall_single_xfer", 64'(wr8), 64'd1);
    compare_log();

    // read of addr 4 corrupted
    corrupt_en = 1; corrupt_addr = 32'd4;
    run(-1, cyc);
    corrupt_en = 0;
    chk("corrupt_status", 64'({done, pass, err_count}), 64'({1'b1, 1'b0, 16'd1}));

    // read of op 1 never answered; late response during the next RD_REQ
    drop_en = 1; drop_addr = 32'd4;
    stall_en = 1; stall_write = 0; stall_addr = 32'd8; stall_n = 2; stall_used = 0;
    inject_late = 1;
    run(-1, cyc);
    drop_en = 0; stall_en = 0; inject_late = 0;
    chk("timeout_wait", 64'(last_wait), 64'd10);
    chk("timeout_status", 64'({done, pass, err_count}), 64'({1'b1, 1'b0, 16'd1}));
    chk("timeout_cycles", 64'(cyc), 64'd28);
    compare_log();

    // reset during WR_WAIT of op 2
    log_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      if (req_valid && req_write && req_addr == 32'd8) found = 1;
      else @(negedge clk);
    end
    chk("reach_op2", 64'(found), 64'd1);
    @(negedge clk);
    chk("in_wr_wait", 64'({busy, req_valid, op_index}), 64'({1'b1, 1'b0, 16'd2}));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", 64'({req_valid, req_write, busy, done, pass, err_count, op_index}), 64'd0);
    chk("midrst_bus", {req_addr, req_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 64'({busy, done, req_valid}), 64'd0);
    run(-1, cyc);
    chk("rerun_cycles", 64'(cyc), 64'd17);
    chk("rerun_status", 64'({done, pass, err_count}), 64'({1'b1, 1'b1, 16'd0}));
    compare_log();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
